// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared encodings for the IFU thread scheduler: thread FSM states,
// TCR bit positions, scheduler states and a small rotate helper.
package sparc_ifu_thrsched_pkg;

  localparam int NTHR = 4;

  localparam logic [4:0] THRFSM_IDLE     = 5'b00000;
  localparam logic [4:0] THRFSM_HALT     = 5'b00010;
  localparam logic [4:0] THRFSM_WAIT     = 5'b00001;
  localparam logic [4:0] THRFSM_RDY      = 5'b11001;
  localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
  localparam logic [4:0] THRFSM_RUN      = 5'b00101;
  localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;

  localparam int TCR_RUN_BIT = 2;
  localparam int TCR_RDY_BIT = 4;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_RUN  = 1'b1
  } sched_state_e;

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/sparc_ifu_thrsched_if.sv
// Bundle between the scheduler and the thread FSMs / fcl: thread states
// and control in, schedule/switch and fetch ownership out.
interface sparc_ifu_thrsched_if;
  logic [4:0] t0_state;
  logic [4:0] t1_state;
  logic [4:0] t2_state;
  logic [4:0] t3_state;
  logic       stall_d;
  logic       force_sw;
  logic [3:0] schedule;
  logic       switch_out;
  logic [3:0] thr_f;
  logic       multi_run_err;

  modport master (
    output t0_state, t1_state, t2_state, t3_state, stall_d, force_sw,
    input  schedule, switch_out, thr_f, multi_run_err
  );

  modport slave (
    input  t0_state, t1_state, t2_state, t3_state, stall_d, force_sw,
    output schedule, switch_out, thr_f, multi_run_err
  );
endinterface

// File: rtl/sparc_ifu_thrsched_rrpick.sv
// Combinational 4-way rotating priority picker: grants the first request
// at or above the one-hot pointer, wrapping from 3 back to 0.
module sparc_ifu_rrpick (
  input  logic [3:0] req,
  input  logic [3:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);

  always_comb begin
    logic [1:0] base;
    logic [1:0] idx;
    logic       found;
    // NOTE: every variable gets a default before the loops so no latch is inferred.
    base  = '0;
    idx   = '0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < 4; i++) begin
      if (ptr[i]) base = 2'(i);
    end
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// Per-core thread scheduler: picks the next ready thread round-robin
// (non-speculative first), switches out the running one and tracks fetch ownership.
module sparc_ifu_thrsched
  import sparc_ifu_thrsched_pkg::*;
#(
  parameter int NTHR = 4
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  se,
  input  logic                  si,
  output logic                  so,
  sparc_ifu_thrsched_if.slave   bus
);

  logic [4:0]      st [NTHR];
  logic [NTHR-1:0] rdy, srdy, run;
  logic [NTHR-1:0] cand_ns, cand_sp, gnt_ns, gnt_sp, pick;
  logic            any_ns, any_sp, any_cand, cur_run, multi_run;

  sched_state_e    state, nxt_state;
  logic [NTHR-1:0] thr_f, nxt_thr_f;
  logic [NTHR-1:0] rr_ptr, nxt_rr_ptr;
  logic            err, nxt_err;
  logic [NTHR-1:0] sched;
  logic            sw;

  assign st[0] = bus.t0_state;
  assign st[1] = bus.t1_state;
  assign st[2] = bus.t2_state;
  assign st[3] = bus.t3_state;

  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      rdy[i]  = (st[i] == THRFSM_RDY);
      srdy[i] = (st[i] == THRFSM_SPEC_RDY);
      run[i]  = st[i][TCR_RUN_BIT];
    end
  end

  // The thread already owning fetch is never a candidate.
  assign cand_ns = rdy  & ~thr_f;
  assign cand_sp = srdy & ~thr_f;

  sparc_ifu_rrpick u_pick_ns (.req(cand_ns), .ptr(rr_ptr), .gnt(gnt_ns), .any(any_ns));
  sparc_ifu_rrpick u_pick_sp (.req(cand_sp), .ptr(rr_ptr), .gnt(gnt_sp), .any(any_sp));

  assign pick      = any_ns ? gnt_ns : gnt_sp;
  assign any_cand  = any_ns | any_sp;
  assign cur_run   = |(run & thr_f);
  assign multi_run = (run & (run - 1'b1)) != '0;

  always_comb begin
    nxt_state = state;
    nxt_thr_f = thr_f;
    sched     = '0;
    sw        = 1'b0;
    unique case (state)
      SW_IDLE: begin
        if (!bus.stall_d && any_cand) begin
          sched     = pick;
          nxt_thr_f = pick;
          nxt_state = SW_RUN;
        end
      end
      SW_RUN: begin
        if (!cur_run) begin
          // Owner left RUN by itself: behave as idle, never switch it out.
          if (!any_cand) begin
            nxt_thr_f = '0;
            nxt_state = SW_IDLE;
          end else if (!bus.stall_d) begin
            sched     = pick;
            nxt_thr_f = pick;
          end
        end else if (bus.stall_d) begin
          sched = '0;
        end else if (any_cand) begin
          sw        = 1'b1;
          sched     = pick;
          nxt_thr_f = pick;
        end else if (bus.force_sw) begin
          sw        = 1'b1;
          nxt_thr_f = '0;
          nxt_state = SW_IDLE;
        end
      end
      default: nxt_state = SW_IDLE;
    endcase
  end

  assign bus.schedule   = rst_l ? sched : '0;
  assign bus.switch_out = rst_l & sw;

  assign nxt_rr_ptr = (bus.schedule != '0) ? rotl1(bus.schedule) : rr_ptr;
  assign nxt_err    = err | multi_run;

  // Scan chain order, MSB first out: sched_fsm, thr_f, rr_ptr, multi_run_err.
  localparam int SCAN_W = 2 * NTHR + 2;
  logic [SCAN_W-1:0] scan_q, scan_d;

  assign scan_d = {nxt_state, nxt_thr_f, nxt_rr_ptr, nxt_err};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
    if (se)          scan_q <= {scan_q[SCAN_W-2:0], si};
    else if (!rst_l) scan_q <= {SW_IDLE, {NTHR{1'b0}}, {{(NTHR-1){1'b0}}, 1'b1}, 1'b0};
    else             scan_q <= scan_d;
  end

  assign state  = sched_state_e'(scan_q[SCAN_W-1]);
  assign thr_f  = scan_q[SCAN_W-2 -: NTHR];
  assign rr_ptr = scan_q[NTHR : 1];
  assign err    = scan_q[0];
  assign so     = scan_q[SCAN_W-1];

  assign bus.thr_f         = thr_f;
  assign bus.multi_run_err = err;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Scoreboard bench for sparc_ifu_thrsched: directed per-cycle vectors push
// expectations, a negedge monitor pops and compares the DUT outputs.
module tb_sparc_ifu_thrsched;

  localparam logic [4:0] I  = 5'b00000;
  localparam logic [4:0] W  = 5'b00001;
  localparam logic [4:0] RD = 5'b11001;
  localparam logic [4:0] SR = 5'b10011;
  localparam logic [4:0] RN = 5'b00101;
  localparam logic [4:0] SN = 5'b00111;

  typedef struct {
    string      name;
    logic [3:0] sched;
    logic       sw;
    logic [3:0] thr;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l, se, si, so;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  sparc_ifu_thrsched_if bus ();

  sparc_ifu_thrsched dut (
    .clk   (clk),
    .rst_l (rst_l),
    .se    (se),
    .si    (si),
    .so    (so),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, " schedule"},   bus.schedule,                e.sched);
      check({e.name, " switch_out"}, {3'b000, bus.switch_out},    {3'b000, e.sw});
      check({e.name, " thr_f"},      bus.thr_f,                   e.thr);
      check({e.name, " err"},        {3'b000, bus.multi_run_err}, {3'b000, e.err});
    end
  end

  task automatic step(input string name,
                      input logic [4:0] s0, s1, s2, s3,
                      input logic stall, frc, rst,
                      input logic [3:0] e_sched, input logic e_sw,
                      input logic [3:0] e_thr, input logic e_err);
    exp_t e;
    bus.t0_state = s0;
    bus.t1_state = s1;
    bus.t2_state = s2;
    bus.t3_state = s3;
    bus.stall_d  = stall;
    bus.force_sw = frc;
    rst_l        = rst;
    e.name  = name;
    e.sched = e_sched;
    e.sw    = e_sw;
    e.thr   = e_thr;
    e.err   = e_err;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_l = 1'b0;
    se    = 1'b0;
    si    = 1'b0;
    bus.t0_state = I; bus.t1_state = I; bus.t2_state = I; bus.t3_state = I;
    bus.stall_d  = 1'b0;
    bus.force_sw = 1'b0;
    @(posedge clk);
    #1;
    //       name     t0  t1  t2  t3  stl frc rst  sched    sw    thr_f    err
    step("reset",     RD, I,  I,  I,  0,  0,  0,  4'b0000, 0, 4'b0000, 0);
    step("t1_first",  RD, I,  I,  I,  0,  0,  1,  4'b0001, 0, 4'b0000, 0);
    step("t1_run",    RN, I,  I,  I,  0,  0,  1,  4'b0000, 0, 4'b0001, 0);
    step("t2_sw1",    RN, RD, RD, I,  0,  0,  1,  4'b0010, 1, 4'b0001, 0);
    step("t2_sw2",    RD, RN, RD, I,  0,  0,  1,  4'b0100, 1, 4'b0010, 0);
    step("t2_wrap",   RD, RD, RN, I,  0,  0,  1,  4'b0001, 1, 4'b0100, 0);
    step("t3_nspec",  RN, SR, RD, I,  0,  0,  1,  4'b0100, 1, 4'b0001, 0);
    step("t4_stall0", RD, SR, RN, I,  1,  0,  1,  4'b0000, 0, 4'b0100, 0);
    step("t4_stall1", RD, SR, RN, I,  1,  0,  1,  4'b0000, 0, 4'b0100, 0);
    step("t4_stall2", RD, SR, RN, I,  1,  0,  1,  4'b0000, 0, 4'b0100, 0);
    step("t4_go",     RD, SR, RN, I,  0,  0,  1,  4'b0001, 1, 4'b0100, 0);
    step("t5_to_t1",  RN, RD, I,  I,  0,  0,  1,  4'b0010, 1, 4'b0001, 0);
    step("t5_hold",   I,  RN, I,  I,  0,  0,  1,  4'b0000, 0, 4'b0010, 0);
    step("t5_leave",  I,  W,  I,  RD, 0,  0,  1,  4'b1000, 0, 4'b0010, 0);
    step("t5_nocand", I,  W,  I,  W,  0,  0,  1,  4'b0000, 0, 4'b1000, 0);
    step("t5_idle",   W,  W,  W,  W,  0,  0,  1,  4'b0000, 0, 4'b0000, 0);
    step("t5_sched0", RD, I,  I,  I,  0,  0,  1,  4'b0001, 0, 4'b0000, 0);
    step("t5_fstall", RN, I,  I,  I,  1,  1,  1,  4'b0000, 0, 4'b0001, 0);
    step("t5_force",  RN, I,  I,  I,  0,  1,  1,  4'b0000, 1, 4'b0001, 0);
    step("t5_resched",RD, I,  I,  I,  0,  0,  1,  4'b0001, 0, 4'b0000, 0);
    step("t6_multi",  RN, I,  SN, I,  0,  0,  1,  4'b0000, 0, 4'b0001, 0);
    step("t6_err",    RN, I,  I,  I,  0,  0,  1,  4'b0000, 0, 4'b0001, 1);
    step("t6_sticky", RN, I,  I,  I,  0,  0,  1,  4'b0000, 0, 4'b0001, 1);
    step("t6_rst",    RN, RD, I,  I,  0,  0,  0,  4'b0000, 0, 4'b0001, 1);
    step("t6_ptr",    RD, I,  I,  RD, 0,  0,  1,  4'b0001, 0, 4'b0000, 0);
    step("t6_fcand",  RN, I,  I,  RD, 0,  1,  1,  4'b1000, 1, 4'b0001, 0);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 4'(q.size()), 4'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sparc_ifu_thrsched.md
Name: sparc_ifu_thrsched

Overview:
- Per-core thread scheduler that drives the `schedule` and `switch_out` inputs of the four per-thread state machines, and consumes their registered 5-bit states.
- Each cycle it picks one ready thread, round-robin, preferring non-speculative threads.
- It switches out the running thread when another thread is ready or the fcl forces a switch.
- It tracks which thread owns fetch.

Parameters:
NTHR, 4, number of threads; only 4 is supported (one-hot vectors are 4 bits).

Ports:
clk  input  1  core clock
rst_l  input  1  synchronous reset, active low
se  input  1  scan enable
si  input  1  scan in
so  output  1  scan out
t0_state  input  5  registered state of thread 0
t1_state  input  5  registered state of thread 1
t2_state  input  5  registered state of thread 2
t3_state  input  5  registered state of thread 3
stall_d  input  1  pipeline hold; no schedule or switch this cycle
force_sw  input  1  fcl request to switch out the running thread (interrupt, trap)
schedule  output  4  one-hot; thread selected to switch in this cycle
switch_out  output  1  common; the running thread is switched out this cycle
thr_f  output  4  one-hot; thread owning fetch, 0000 when none
multi_run_err  output  1  sticky; more than one thread is in RUN or SPEC_RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst_l is synchronous, active-low.
- Reset values (registered): sched_fsm=SW_IDLE, thr_f=0000, rr_ptr=0001, multi_run_err=0.
- While rst_l=0, schedule and switch_out are forced to 0 combinationally.
- Per-thread state decode (state encodings come from `THRFSM_*`):
  - rdy = state==RDY (11001)
  - srdy = state==SPEC_RDY (10011)
  - run = state[2] (true for RUN and SPEC_RUN)
- Candidate set excludes the thread in thr_f.
  - cand_ns = rdy & ~thr_f
  - cand_sp = srdy & ~thr_f
  - Pick from cand_ns if it is nonzero, otherwise from cand_sp.
- Pick rule: the first set bit at or after rr_ptr, scanning upward with wrap from 3 to 0.
  - A pick is "taken" only when it is driven onto schedule.
  - On a taken pick p: rr_ptr <= rotate_left(p, 1).
  - Example: rr_ptr=0100, candidates t0 and t1 → pick t0.
- schedule and switch_out are Mealy outputs: combinational from current state and inputs. The thread FSMs register them, so the selected thread shows RUN/SPEC_RUN one cycle later.
- sched_fsm states:
  - SW_IDLE (no thread owns fetch):
    - stall_d=1 → hold, outputs 0.
    - Else, if any candidate → schedule=pick, thr_f<=pick, go to SW_RUN.
    - Else → stay.
  - SW_RUN (thread c = thr_f owns fetch):
    - If run[c]=0 (thread left on its own via stall/sw_cond/reset/nuke) → treat as SW_IDLE this cycle; no switch_out. With no candidate: thr_f<=0000, go to SW_IDLE.
    - Else if stall_d=1 → hold, outputs 0. This holds even if force_sw=1; force_sw is not latched.
    - Else if a candidate exists (and force_sw is either value) → switch_out=1, schedule=pick, thr_f<=pick, stay in SW_RUN.
    - Else if force_sw=1 → switch_out=1, schedule=0, thr_f<=0000, go to SW_IDLE.
    - Else → hold.
- The switched-out thread returns to RDY and re-enters the candidate set on the following cycle under normal round-robin.
- switch_out and the running thread's own stall in the same cycle: legal. The thread FSM gives stall priority; the scheduler does not check for this.
- schedule is never multi-hot. schedule is never asserted for the thr_f thread.
- multi_run_err: set when more than one run bit is 1 in any cycle. Cleared only by reset.
- A thread reset (rst_thread) mid-run drops run[c]. The scheduler recovers through the SW_RUN run[c]=0 path.

Decomposition:
- Shared header ifu.h:
  - existing `THRFSM_*` encodings
  - new bit positions `TCR_RUN_BIT`=2 and `TCR_RDY_BIT`=4
  - SW_IDLE/SW_RUN encodings (1 bit)
- One sub-module: sparc_ifu_rrpick, a combinational 4-way rotating priority picker. Inputs: req[3:0], ptr[3:0]. Outputs: gnt[3:0] (one-hot), any.
  - Instantiated twice, once for cand_ns and once for cand_sp; its result then goes through a 2:1 select.
- Flops (with scan chain):
  - dffrl_s (active-low synchronous reset) for sched_fsm, thr_f, rr_ptr, multi_run_err.

Test Plan:
1. Reset, t0=RDY, t1..t3=IDLE, rst_l=1 → cycle 1: schedule=0001, switch_out=0. Cycle 2: thr_f=0001, rr_ptr=0010.
2. t0=RUN (thr_f=0001), t1=RDY, t2=RDY, rr_ptr=0010 → schedule=0010, switch_out=1. Next: thr_f=0010, rr_ptr=0100. Next switch picks t2.
3. rr_ptr=0010, t1=SPEC_RDY, t2=RDY, t0 running → schedule=0100 (non-spec preferred). rr_ptr<=1000.
4. Candidates present, stall_d=1 for 3 cycles → schedule=0000 and switch_out=0 throughout; thr_f unchanged. On the first cycle with stall_d=0, the switch fires.
5. Running t1 goes to WAIT, t3=RDY → schedule=1000, switch_out=0. Then t3 goes to WAIT with no candidates → thr_f=0000, SW_IDLE. Then force_sw with t0 alone running → switch_out=1, schedule=0000.
6. Drive t0=RUN and t2=SPEC_RUN simultaneously → next cycle multi_run_err=1, stays 1. Assert rst_l=0 for one cycle mid-run → multi_run_err=0, thr_f=0000, rr_ptr=0001; schedule and switch_out are 0 during reset.
